sdp_ram_pipe: RTL and testbench

Parametrised single-clock simple dual-port RAM with per-byte write enables, a configurable read-latency pipeline with a valid strobe, and a selectable read-during-write policy. It is the storage element under the AXI-Stream FIFO and other buffers that need deeper read pipelines or partial-word writes. A compile-time option adds per-byte parity protection.

---
 rtl/sdp_ram_pkg.sv | 27 ++
 rtl/sdp_ram_rdpipe.sv | 48 ++++
 rtl/sdp_ram_pipe.sv | 159 +++++++++++++++
 tb/tb_sdp_ram_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM with read pipeline.
package sdp_ram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned MAX_DLEN = 512;
  localparam int unsigned MAX_BLEN = MAX_DLEN / BYTE_W;

  function automatic int unsigned blen(input int unsigned dlen);
    return dlen / BYTE_W;
  endfunction

  // Even parity per byte lane; callers zero-extend and keep the low BLEN bits.
  function automatic logic [MAX_BLEN-1:0] byte_parity(input logic [MAX_DLEN-1:0] data);
    logic [MAX_BLEN-1:0] p;
    p = '0;
    for (int b = 0; b < MAX_BLEN; b++) begin
      p[b] = ^data[BYTE_W*b +: BYTE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/sdp_ram_rdpipe.sv
// Delay line of DEPTH stages for {valid, payload}; payload only advances with valid
// so that each stage holds its last result while idle.
module sdp_ram_rdpipe #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign o_valid = i_valid;
    assign o_data  = i_data;
  end else begin : g_stages
    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valid_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        valid_q[0] <= i_valid;
        if (i_valid) begin
          data_q[0] <= i_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

    assign o_valid = valid_q[DEPTH-1];
    assign o_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/sdp_ram_pipe.sv
// Simple dual-port RAM with byte enables, RD_LAT-cycle read pipeline and RDW policy.
// Define SDP_RAM_PARITY_EN to add per-byte even parity storage and checking.
module sdp_ram_pipe
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DLEN     = 32,
  parameter int unsigned ALEN     = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter rdw_mode_e   RDW_MODE = RDW_NEW,
  localparam int unsigned BLEN    = blen(DLEN)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_wen,
  input  logic [BLEN-1:0] i_wbe,
  input  logic [ALEN-1:0] i_waddr,
  input  logic [DLEN-1:0] i_wdata,
  input  logic            i_perr_inj,
  input  logic            i_ren,
  input  logic [ALEN-1:0] i_raddr,
  output logic            o_rvalid,
  output logic [DLEN-1:0] o_rdata,
  output logic [BLEN-1:0] o_rerr
);

  localparam int unsigned DEPTH = 2 ** ALEN;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $fatal(1, "sdp_ram_pipe: RD_LAT must be in 1..4");
  end
  if (DLEN == 0 || DLEN % BYTE_W != 0 || DLEN > MAX_DLEN) begin : g_bad_dlen
    $fatal(1, "sdp_ram_pipe: DLEN must be a non-zero multiple of 8");
  end

  // Data array and byte-lane writes; intentionally not reset.
  logic [DLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wen) begin
      for (int b = 0; b < BLEN; b++) begin
        if (i_wbe[b]) begin
          mem[i_waddr][BYTE_W*b +: BYTE_W] <= i_wdata[BYTE_W*b +: BYTE_W];
        end
      end
    end
  end

  // Lanes to forward from the concurrent write; always empty in RDW_OLD.
  logic [BLEN-1:0] fwd_be_d;
  assign fwd_be_d = (RDW_MODE == RDW_NEW && i_wen && i_waddr == i_raddr) ? i_wbe : '0;

  logic            s1_valid_q;
  logic [DLEN-1:0] s1_rdata_q;
  logic [DLEN-1:0] s1_wdata_q;
  logic [BLEN-1:0] s1_fwd_be_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_rdata_q  <= '0;
      s1_wdata_q  <= '0;
      s1_fwd_be_q <= '0;
    end else begin
      s1_valid_q <= i_ren;
      if (i_ren) begin
        s1_rdata_q  <= mem[i_raddr];
        s1_wdata_q  <= i_wdata;
        s1_fwd_be_q <= fwd_be_d;
      end
    end
  end

  logic [DLEN-1:0] s1_data;

  always_comb begin
    s1_data = s1_rdata_q;
    for (int b = 0; b < BLEN; b++) begin
      if (s1_fwd_be_q[b]) begin
        s1_data[BYTE_W*b +: BYTE_W] = s1_wdata_q[BYTE_W*b +: BYTE_W];
      end
    end
  end

`ifdef SDP_RAM_PARITY_EN
  function automatic logic [BLEN-1:0] lane_parity(input logic [DLEN-1:0] d);
    logic [MAX_BLEN-1:0] full;
    full = byte_parity(MAX_DLEN'(d));
    return full[BLEN-1:0];
  endfunction

  logic [BLEN-1:0] mem_par [DEPTH];
  logic [BLEN-1:0] wpar;

  // Injection flips every lane; only enabled lanes are stored or forwarded.
  assign wpar = lane_parity(i_wdata) ^ {BLEN{i_perr_inj}};

  always_ff @(posedge clk) begin
    if (i_wen) begin
      for (int b = 0; b < BLEN; b++) begin
        if (i_wbe[b]) begin
          mem_par[i_waddr][b] <= wpar[b];
        end
      end
    end
  end

  logic [BLEN-1:0] s1_rpar_q;
  logic [BLEN-1:0] s1_wpar_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_rpar_q <= '0;
      s1_wpar_q <= '0;
    end else if (i_ren) begin
      s1_rpar_q <= mem_par[i_raddr];
      s1_wpar_q <= wpar;
    end
  end

  logic [BLEN-1:0] s1_par;
  assign s1_par = (s1_rpar_q & ~s1_fwd_be_q) | (s1_wpar_q & s1_fwd_be_q);

  logic [BLEN-1:0] p_par;
  logic [DLEN-1:0] p_data;

  sdp_ram_rdpipe #(
    .DEPTH (RD_LAT - 1),
    .W     (DLEN + BLEN)
  ) u_rdpipe (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (s1_valid_q),
    .i_data  ({s1_par, s1_data}),
    .o_valid (o_rvalid),
    .o_data  ({p_par, p_data})
  );

  assign o_rdata = p_data;
  assign o_rerr  = lane_parity(p_data) ^ p_par;
`else
  logic unused_perr_inj;
  assign unused_perr_inj = i_perr_inj;

  sdp_ram_rdpipe #(
    .DEPTH (RD_LAT - 1),
    .W     (DLEN)
  ) u_rdpipe (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (s1_valid_q),
    .i_data  (s1_data),
    .o_valid (o_rvalid),
    .o_data  (o_rdata)
  );

  assign o_rerr = '0;
`endif

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Directed bench driving three configurations in lockstep: RD_LAT=3/NEW, 4/NEW, 1/OLD.
module tb_sdp_ram_pipe;
  import sdp_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  wbe = '0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        perr_inj = 1'b0;
  logic        ren = 1'b0;
  logic [3:0]  raddr = '0;

  logic        rv_a, rv_b, rv_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [3:0]  re_a, re_b, re_c;

  always #5 clk = ~clk;

  sdp_ram_pipe #(.DLEN(32), .ALEN(4), .RD_LAT(3), .RDW_MODE(RDW_NEW)) dut_a (
    .clk(clk), .rstn(rstn), .i_wen(wen), .i_wbe(wbe), .i_waddr(waddr), .i_wdata(wdata),
    .i_perr_inj(perr_inj), .i_ren(ren), .i_raddr(raddr),
    .o_rvalid(rv_a), .o_rdata(rd_a), .o_rerr(re_a)
  );

  sdp_ram_pipe #(.DLEN(32), .ALEN(4), .RD_LAT(4), .RDW_MODE(RDW_NEW)) dut_b (
    .clk(clk), .rstn(rstn), .i_wen(wen), .i_wbe(wbe), .i_waddr(waddr), .i_wdata(wdata),
    .i_perr_inj(perr_inj), .i_ren(ren), .i_raddr(raddr),
    .o_rvalid(rv_b), .o_rdata(rd_b), .o_rerr(re_b)
  );

  sdp_ram_pipe #(.DLEN(32), .ALEN(4), .RD_LAT(1), .RDW_MODE(RDW_OLD)) dut_c (
    .clk(clk), .rstn(rstn), .i_wen(wen), .i_wbe(wbe), .i_waddr(waddr), .i_wdata(wdata),
    .i_perr_inj(perr_inj), .i_ren(ren), .i_raddr(raddr),
    .o_rvalid(rv_c), .o_rdata(rd_c), .o_rerr(re_c)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [31:0] model [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // One clock of stimulus; returns 1 time unit after the capturing edge.
  task automatic cycle(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic inj, input logic r,
                       input logic [3:0] ra);
    @(negedge clk);
    wen = w; waddr = wa; wdata = wd; wbe = be; perr_inj = inj; ren = r; raddr = ra;
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; perr_inj = 1'b0; wbe = '0;
  endtask

  // Called right after the read edge; checks valid timing and data of every instance.
  task automatic expect_read(input string tag, input logic [31:0] exp_new,
                             input logic [31:0] exp_old, input logic [3:0] exp_err);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      check_eq({tag, " valid l3"}, 32'(rv_a), 32'(k == 3));
      check_eq({tag, " valid l4"}, 32'(rv_b), 32'(k == 4));
      check_eq({tag, " valid l1"}, 32'(rv_c), 32'(k == 1));
      if (k == 3) begin
        check_eq({tag, " data l3"}, rd_a, exp_new);
        check_eq({tag, " rerr l3"}, 32'(re_a), 32'(exp_err));
      end
      if (k == 4) begin
        check_eq({tag, " data l4"}, rd_b, exp_new);
        check_eq({tag, " rerr l4"}, 32'(re_b), 32'(exp_err));
      end
      if (k == 1) begin
        check_eq({tag, " data l1"}, rd_c, exp_old);
        check_eq({tag, " rerr l1"}, 32'(re_c), 32'(exp_err));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check_eq("reset rvalid l3", 32'(rv_a), 32'd0);
    check_eq("reset rvalid l4", 32'(rv_b), 32'd0);
    check_eq("reset rvalid l1", 32'(rv_c), 32'd0);
    check_eq("reset rdata l3", rd_a, 32'd0);
    check_eq("reset rdata l4", rd_b, 32'd0);
    check_eq("reset rdata l1", rd_c, 32'd0);
    check_eq("reset rerr l3", 32'(re_a), 32'd0);
    check_eq("reset rerr l1", 32'(re_c), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int a = 0; a < 16; a++) begin
      cycle(1'b1, 4'(a), (32'h0101_0101 * 32'(a)) ^ 32'h5A00_00C3, 4'hF, 1'b0, 1'b0, 4'h0);
    end

    // Basic write then read
    cycle(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd3);
    expect_read("basic", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0);

    // Partial write: lanes 0 and 2 replaced
    cycle(1'b1, 4'd5, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd5);
    expect_read("partial", 32'h11BB_33DD, 32'h11BB_33DD, 4'h0);

    // Same-cycle collision, then follow-up read
    cycle(1'b1, 4'd7, 32'h0, 4'hF, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 4'd7, 32'hFFFF_FFFF, 4'b0011, 1'b0, 1'b1, 4'd7);
    expect_read("rdw", 32'h0000_FFFF, 32'h0000_0000, 4'h0);
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd7);
    expect_read("rdw next", 32'h0000_FFFF, 32'h0000_FFFF, 4'h0);

    // Streaming: reads 0..15 on consecutive edges
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      ren = (c < 16);
      raddr = 4'(c);
      @(posedge clk);
      #1;
      begin
        int ia, ib, ic;
        ia = c - 2;
        ib = c - 3;
        ic = c;
        check_eq("stream valid l3", 32'(rv_a), 32'(ia >= 0 && ia < 16));
        check_eq("stream valid l4", 32'(rv_b), 32'(ib >= 0 && ib < 16));
        check_eq("stream valid l1", 32'(rv_c), 32'(ic < 16));
        if (ia >= 0 && ia < 16) check_eq("stream data l3", rd_a, model[ia]);
        if (ib >= 0 && ib < 16) check_eq("stream data l4", rd_b, model[ib]);
        if (ic < 16) check_eq("stream data l1", rd_c, model[ic]);
      end
    end
    ren = 1'b0;
    check_eq("idle hold l3", rd_a, model[15]);
    check_eq("idle hold l4", rd_b, model[15]);
    check_eq("idle hold l1", rd_c, model[15]);

    // Reset with two reads in flight
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd3);
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd5);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_eq("midreset rvalid l4", 32'(rv_b), 32'd0);
    check_eq("midreset rdata l4", rd_b, 32'd0);
    check_eq("midreset rdata l3", rd_a, 32'd0);
    check_eq("midreset rvalid l1", 32'(rv_c), 32'd0);
    check_eq("midreset rdata l1", rd_c, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq("no stale l3", 32'(rv_a), 32'd0);
      check_eq("no stale l4", 32'(rv_b), 32'd0);
      check_eq("no stale l1", 32'(rv_c), 32'd0);
    end
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd3);
    expect_read("reread a3", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0);
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd5);
    expect_read("reread a5", 32'h11BB_33DD, 32'h11BB_33DD, 4'h0);

    // Parity injection and clean rewrite
    cycle(1'b1, 4'd2, 32'h0F0F_1234, 4'hF, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd2);
`ifdef SDP_RAM_PARITY_EN
    expect_read("perr inj", 32'h0F0F_1234, 32'h0F0F_1234, 4'hF);
`else
    expect_read("perr inj", 32'h0F0F_1234, 32'h0F0F_1234, 4'h0);
`endif
    cycle(1'b1, 4'd2, 32'h0F0F_1234, 4'hF, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1, 4'd2);
    expect_read("perr clean", 32'h0F0F_1234, 32'h0F0F_1234, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
